rv_encoder: RTL and testbench
=============================

RV_ENCODER -- requirements
Module: rv_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO depth (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port base_load  input  1  load base_addr into address counter.
REQ-005 SHALL have port base_addr  input  32  new program address.
REQ-006 SHALL have port in_valid  input  1  field bundle valid.
REQ-007 SHALL have port in_ready  output  1  bundle accepted when in_valid & in_ready.
REQ-008 SHALL have port in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal.
REQ-009 SHALL have ports in_opcode (7), in_funct3 (3), in_funct7 (7), in_rd (5), in_rs1 (5), in_rs2 (5), in_imm (32), all inputs, RV32I fields.
REQ-010 SHALL have port out_valid  output  1  encoded word available.
REQ-011 SHALL have port out_ready  input  1  consumer takes word when out_valid & out_ready.
REQ-012 SHALL have ports out_word (32), out_addr (32), out_err (1), all outputs: machine word, its address, encode error.
REQ-013 SHALL have port word_count  output  16  words delivered since reset/base_load.

Function
REQ-014 SHALL encode per RV32I: R {funct7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-015 SHALL, for illegal in_fmt, store out_word=0x00000000 with out_err=1.
REQ-016 SHALL push {word, addr, err} into a DEPTH-entry FIFO on each accepted bundle; out_* SHALL present the FIFO head.
REQ-017 SHALL make an accepted bundle visible on out_* the cycle after acceptance when FIFO empty (latency 1).
REQ-018 SHALL drive in_ready = FIFO not full; no bypass when full, even if popping same cycle.
REQ-019 SHALL keep occupancy unchanged on simultaneous push and pop; delivery order SHALL equal acceptance order.
REQ-020 SHALL hold out_* stable while out_valid & !out_ready.
REQ-021 SHALL tag each accepted bundle with the address counter, then advance counter by 4, wrapping 0xFFFFFFFC->0.
REQ-022 SHALL on base_load set counter to {base_addr[31:2],2'b00}; a bundle accepted in the same cycle SHALL take that address and counter SHALL become it+4.
REQ-023 SHALL increment word_count on each pop, saturating at 0xFFFF; base_load SHALL clear it, winning over a simultaneous pop.

Reset
REQ-024 SHALL on rst_n low immediately flush FIFO, set out_valid=0, out_word=0, out_addr=0, out_err=0, counter=0, word_count=0, in_ready=0 during reset, 1 after release.
REQ-025 SHALL discard all in-flight words on reset mid-operation; no partial word SHALL appear after release.

Configuration
REQ-026 SHALL, when RV_ENC_RANGE_CHECK_EN defined, set out_err=1 (word still encoded from truncated bits) if: I/S imm outside [-2048,2047]; B imm outside [-4096,4094] or imm[0]=1; U imm[11:0]!=0; J imm outside [-1048576,1048574] or imm[0]=1.
REQ-027 SHALL, when RV_ENC_RANGE_CHECK_EN undefined, set out_err only for illegal in_fmt.

Verification
REQ-028 SHALL cover: I op=0x13 f3=0 rd=1 rs1=0 imm=5 -> next cycle out_valid=1, out_word=0x00500093, out_addr=0.
REQ-029 SHALL cover: R op=0x33 f3=0 f7=0 rd=3 rs1=1 rs2=2 then B op=0x63 f3=0 rs1=1 rs2=2 imm=8 -> 0x002081B3 @0, 0x00208463 @4.
REQ-030 SHALL cover: out_ready=0, five bundles offered -> in_ready=0 after 4th; release -> five words in order, addrs 0,4,8,12,16, word_count=5.
REQ-031 SHALL cover: base_load=1 base_addr=0x1003 with bundle accepted -> out_addr 0x1000, next 0x1004, word_count cleared.
REQ-032 SHALL cover: I imm=4096 rd=1 op=0x13 -> out_word=0x00000093, out_err=1 with macro, 0 without; in_fmt=7 -> word 0, out_err=1.
REQ-033 SHALL cover: rst_n low with 3 words queued -> out_valid=0 immediately; after release first new word at addr 0.

Source files
------------

// File: rtl/rv_encoder.sv
// RV32I field-bundle encoder: packs instruction fields into a 32-bit word, tags it with a program address
// and queues {word, addr, err} in a DEPTH-entry FIFO. Optional immediate range checking: RV_ENC_RANGE_CHECK_EN.
module rv_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        base_load,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] word_count
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [31:0]     r_addr;
  logic [15:0]     r_word_count;

  logic [31:0]     w_word;
  logic            w_err;
  logic [31:0]     w_base;
  logic [31:0]     w_tag_addr;
  logic            w_push;
  logic            w_pop;
  logic            w_unused_base_lsbs;

`ifdef RV_ENC_RANGE_CHECK_EN
  logic w_imm12_oor;
  logic w_imm13_oor;
  logic w_imm21_oor;

  // An immediate fits in N signed bits when bits [31:N-1] are all copies of the sign.
  assign w_imm12_oor = !((&in_imm[31:11]) || !(|in_imm[31:11]));
  assign w_imm13_oor = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
  assign w_imm21_oor = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
`endif

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_word = '0;
    w_err  = 1'b0;
    case (in_fmt)
      FMT_R: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
`ifdef RV_ENC_RANGE_CHECK_EN
        w_err  = w_imm12_oor;
`endif
      end
      FMT_S: begin
        w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
`ifdef RV_ENC_RANGE_CHECK_EN
        w_err  = w_imm12_oor;
`endif
      end
      FMT_B: begin
        w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                  in_imm[4:1], in_imm[11], in_opcode};
`ifdef RV_ENC_RANGE_CHECK_EN
        w_err  = w_imm13_oor;
`endif
      end
      FMT_U: begin
        w_word = {in_imm[31:12], in_rd, in_opcode};
`ifdef RV_ENC_RANGE_CHECK_EN
        w_err  = |in_imm[11:0];
`endif
      end
      FMT_J: begin
        w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
`ifdef RV_ENC_RANGE_CHECK_EN
        w_err  = w_imm21_oor;
`endif
      end
      default: begin
        w_word = '0;
        w_err  = 1'b1;
      end
    endcase
  end

  // Holding in_ready low through reset keeps any bundle from landing in a FIFO that is being flushed.
  assign in_ready  = rst_n && (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_base             = {base_addr[31:2], 2'b00};
  assign w_tag_addr         = base_load ? w_base : r_addr;
  assign w_unused_base_lsbs = ^base_addr[1:0];

  // Empty FIFO shows zeros so stale storage never leaks out after a flush.
  assign out_word   = out_valid ? r_mem[r_rd_ptr].word : '0;
  assign out_addr   = out_valid ? r_mem[r_rd_ptr].addr : '0;
  assign out_err    = out_valid ? r_mem[r_rd_ptr].err  : 1'b0;
  assign word_count = r_word_count;

  // NOTE: storage is not reset; validity is tracked solely by r_count, so clearing it is enough.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{word: w_word, addr: w_tag_addr, err: w_err};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_addr       <= '0;
      r_word_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase

      if (w_push) begin
        r_addr <= w_tag_addr + 32'd4;
      end else if (base_load) begin
        r_addr <= w_base;
      end

      // A base_load restarts the delivered-word tally even if a word leaves this cycle.
      if (base_load) begin
        r_word_count <= '0;
      end else if (w_pop && (r_word_count != 16'hFFFF)) begin
        r_word_count <= r_word_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rv_encoder.sv
// Directed self-checking bench for rv_encoder: encodings, FIFO backpressure, base_load and mid-run reset.
module tb_rv_encoder;

  logic        clk;
  logic        rst_n;
  logic        base_load;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] word_count;

  int n_cmp = 0;
  int n_mis = 0;

  rv_encoder #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .base_load (base_load),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RV_ENC_RANGE_CHECK_EN
  localparam logic EXP_RANGE_ERR = 1'b1;
`else
  localparam logic EXP_RANGE_ERR = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    in_fmt    = fmt;
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  task automatic push_b(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
    set_fields(fmt, op, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) step();
    if (!in_ready) check("push_timeout", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp_word,
                         input logic [31:0] exp_addr, input logic exp_err);
    for (int k = 0; k < 20 && !out_valid; k++) step();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_word"}, out_word, exp_word);
    check({tag, "_addr"}, out_addr, exp_addr);
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    base_load = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    base_load = 1'b0;
    base_addr = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);

    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_word_count", {16'd0, word_count}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // addi x1, x0, 5: visible the cycle right after acceptance
    push_b(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    check("lat1_valid", {31'd0, out_valid}, 32'd1);
    check("lat1_word", out_word, 32'h0050_0093);
    check("lat1_addr", out_addr, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    do_reset();
    push_b(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    push_b(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    pop_chk("r_add", 32'h0020_81B3, 32'd0, 1'b0);
    pop_chk("b_beq", 32'h0020_8463, 32'd4, 1'b0);

    // sw x5,-4(x2); lui x5,0x12345; jal x1,2048
    push_b(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC);
    push_b(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    push_b(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    pop_chk("s_sw", 32'hFE51_2E23, 32'd8, 1'b0);
    pop_chk("u_lui", 32'h1234_52B7, 32'd12, 1'b0);
    pop_chk("j_jal", 32'h0010_00EF, 32'd16, 1'b0);

    // Backpressure: fill four entries, fifth must wait
    do_reset();
    for (int i = 0; i < 4; i++) push_b(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, i);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_head_word", out_word, 32'h0000_0093);
    step();
    check("hold_word", out_word, 32'h0000_0093);
    check("hold_addr", out_addr, 32'd0);
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("nobypass_in_ready", {31'd0, in_ready}, 32'd1);
    check("nobypass_head_addr", out_addr, 32'd4);
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      pop_chk($sformatf("bp%0d", i), 32'h0000_0093 | (i << 20), i * 4, 1'b0);
    end
    check("bp_drained", {31'd0, out_valid}, 32'd0);
    check("bp_word_count", {16'd0, word_count}, 32'd5);

    // base_load with simultaneous accept and pop: clear wins, bundle takes aligned base
    push_b(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd0);
    check("pre_bl_addr", out_addr, 32'd20);
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    base_load = 1'b1;
    base_addr = 32'h0000_1003;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    base_load = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bl_word_count", {16'd0, word_count}, 32'd0);
    push_b(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2);
    pop_chk("bl0", 32'h0010_0093, 32'h0000_1000, 1'b0);
    pop_chk("bl1", 32'h0020_0093, 32'h0000_1004, 1'b0);
    check("bl_word_count2", {16'd0, word_count}, 32'd2);

    // Out-of-range immediate and illegal format
    push_b(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
    push_b(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    pop_chk("imm_oor", 32'h0000_0093, 32'h0000_1008, EXP_RANGE_ERR);
    pop_chk("bad_fmt", 32'h0000_0000, 32'h0000_100C, 1'b1);

    // Reset with three words queued
    for (int i = 7; i < 10; i++) push_b(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, i);
    check("q3_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_word", out_word, 32'd0);
    check("mid_rst_addr", out_addr, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_wc", {16'd0, word_count}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check("post_rst_empty", {31'd0, out_valid}, 32'd0);
    push_b(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h7FF);
    pop_chk("post_rst", 32'h7FF0_0093, 32'd0, 1'b0);
    check("post_rst_drained", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
